// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM control into a word-aligned D-cache request and
// stalls until the response. Optional misalignment trap: define LSU_MISALIGN_CHECK_EN.
module mem_stage_lsu #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    input  logic             i_d_mem_resp,
    input  logic [31:0]      i_d_mem_rdata,
    output logic             o_d_mem_read,
    output logic             o_d_mem_write,
    output logic [31:0]      o_d_mem_address,
    output logic [3:0]       o_d_mem_byte_enable,
    output logic [31:0]      o_d_mem_wdata,
    output logic             o_stall,
    output logic [31:0]      o_load_data,
    output logic             o_load_valid,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           r_state;
    logic             r_d_mem_read;
    logic             r_d_mem_write;
    logic [31:0]      r_d_mem_address;
    logic [3:0]       r_d_mem_byte_enable;
    logic [31:0]      r_d_mem_wdata;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [31:0]      r_load_data;
    logic             r_load_valid;
    logic             r_misalign;
    logic [CNT_W-1:0] r_stall_cycles;

    logic        w_req;
    logic        w_is_store;
    logic        w_byte;
    logic        w_half;
    logic        w_word;
    logic        w_misaligned;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_ext;

    assign w_req      = i_mem_read | i_mem_write;
    assign w_is_store = i_mem_write;

    // LBU/LHU encodings are only legal for loads; anything undecoded falls back to a word.
    assign w_byte = (i_funct3 == 3'b000) || (!w_is_store && (i_funct3 == 3'b100));
    assign w_half = (i_funct3 == 3'b001) || (!w_is_store && (i_funct3 == 3'b101));
    assign w_word = !w_byte && !w_half;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misaligned = w_req && ((w_half && i_addr[0]) || (w_word && (i_addr[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (w_is_store) begin
            if (w_byte) begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end else if (w_half) begin
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_wdata[15:0]}};
            end
        end
    end

    // Stall covers the issue cycle and every BUSY cycle until the response arrives.
    always_comb begin
        w_stall = 1'b0;
        if (!i_rst) begin
            case (r_state)
                StIdle:  w_stall = w_req && !w_misaligned;
                StBusy:  w_stall = !i_d_mem_resp;
                default: w_stall = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_ld_byte = i_d_mem_rdata[7:0];
        case (r_off)
            2'd0:    w_ld_byte = i_d_mem_rdata[7:0];
            2'd1:    w_ld_byte = i_d_mem_rdata[15:8];
            2'd2:    w_ld_byte = i_d_mem_rdata[23:16];
            default: w_ld_byte = i_d_mem_rdata[31:24];
        endcase
        w_ld_half = r_off[1] ? i_d_mem_rdata[31:16] : i_d_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_load_ext = {24'd0, w_ld_byte};
            3'b001:  w_load_ext = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_load_ext = {16'd0, w_ld_half};
            default: w_load_ext = i_d_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state             <= StIdle;
            r_d_mem_read        <= 1'b0;
            r_d_mem_write       <= 1'b0;
            r_d_mem_address     <= 32'd0;
            r_d_mem_byte_enable <= 4'd0;
            r_d_mem_wdata       <= 32'd0;
            r_funct3            <= 3'd0;
            r_off               <= 2'd0;
            r_load_data         <= 32'd0;
            r_load_valid        <= 1'b0;
            r_misalign          <= 1'b0;
            r_stall_cycles      <= '0;
        end else begin
            r_load_valid <= 1'b0;
            r_misalign   <= 1'b0;
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        if (w_misaligned) begin
                            r_misalign <= 1'b1;
                        end else begin
                            r_d_mem_read        <= !w_is_store;
                            r_d_mem_write       <= w_is_store;
                            r_d_mem_address     <= {i_addr[31:2], 2'b00};
                            r_d_mem_byte_enable <= w_be;
                            r_d_mem_wdata       <= w_wdata;
                            r_funct3            <= i_funct3;
                            r_off               <= i_addr[1:0];
                            r_state             <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (i_d_mem_resp) begin
                        r_d_mem_read  <= 1'b0;
                        r_d_mem_write <= 1'b0;
                        r_state       <= StIdle;
                        if (r_d_mem_read) begin
                            r_load_data  <= w_load_ext;
                            r_load_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_d_mem_read        = r_d_mem_read;
    assign o_d_mem_write       = r_d_mem_write;
    assign o_d_mem_address     = r_d_mem_address;
    assign o_d_mem_byte_enable = r_d_mem_byte_enable;
    assign o_d_mem_wdata       = r_d_mem_wdata;
    assign o_stall             = w_stall;
    assign o_load_data         = r_load_data;
    assign o_load_valid        = r_load_valid;
    assign o_misalign          = r_misalign;
    assign o_stall_cycles      = r_stall_cycles;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; the misalignment case follows LSU_MISALIGN_CHECK_EN.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        d_mem_resp;
    logic [31:0] d_mem_rdata;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [31:0] d_mem_address;
    logic [3:0]  d_mem_byte_enable;
    logic [31:0] d_mem_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    int          ns;
    logic [31:0] qa;
    logic [3:0]  qbe;
    logic [31:0] qwd;
    logic        qrd;
    logic        qwr;
    logic        lv;
    logic [31:0] ld;
    logic        rel;

    always #5 clk = ~clk;

    mem_stage_lsu #(
        .CNT_W(32)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_mem_read          (mem_read),
        .i_mem_write         (mem_write),
        .i_funct3            (funct3),
        .i_addr              (addr),
        .i_wdata             (wdata),
        .i_d_mem_resp        (d_mem_resp),
        .i_d_mem_rdata       (d_mem_rdata),
        .o_d_mem_read        (d_mem_read),
        .o_d_mem_write       (d_mem_write),
        .o_d_mem_address     (d_mem_address),
        .o_d_mem_byte_enable (d_mem_byte_enable),
        .o_d_mem_wdata       (d_mem_wdata),
        .o_stall             (stall),
        .o_load_data         (load_data),
        .o_load_valid        (load_valid),
        .o_misalign          (misalign),
        .o_stall_cycles      (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access with a cache that answers after `waits` BUSY cycles; inputs drop after resp.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int waits,
                              input logic [31:0] rdata);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        ns = int'(stall);
        @(posedge clk); #1;
        qa  = d_mem_address;
        qbe = d_mem_byte_enable;
        qwd = d_mem_wdata;
        qrd = d_mem_read;
        qwr = d_mem_write;
        for (int i = 0; i < waits; i++) begin
            ns += int'(stall);
            @(posedge clk); #1;
        end
        d_mem_resp  = 1'b1;
        d_mem_rdata = rdata;
        #1;
        ns += int'(stall);
        @(posedge clk); #1;
        d_mem_resp = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        #1;
        lv  = load_valid;
        ld  = load_data;
        rel = d_mem_read | d_mem_write;
    endtask

    initial begin
        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        funct3      = 3'b000;
        addr        = 32'd0;
        wdata       = 32'd0;
        d_mem_resp  = 1'b0;
        d_mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", 32'(d_mem_read), 32'd0);
        chk("rst_wr", 32'(d_mem_write), 32'd0);
        chk("rst_addr", d_mem_address, 32'd0);
        chk("rst_be", 32'(d_mem_byte_enable), 32'd0);
        chk("rst_wdata", d_mem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ldata", load_data, 32'd0);
        chk("rst_lvalid", 32'(load_valid), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_scnt", stall_cycles, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // LW, cache answers after 3 wait cycles
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'd0, 3, 32'hDEAD_BEEF);
        chk("lw_addr", qa, 32'h0000_1004);
        chk("lw_be", 32'(qbe), 32'h0000_000F);
        chk("lw_rd", 32'(qrd), 32'd1);
        chk("lw_wr", 32'(qwr), 32'd0);
        chk("lw_stall", 32'(ns), 32'd4);
        chk("lw_lvalid", 32'(lv), 32'd1);
        chk("lw_ldata", ld, 32'hDEAD_BEEF);
        chk("lw_release", 32'(rel), 32'd0);
        chk("lw_scnt", stall_cycles, 32'd4);
        @(posedge clk); #1;
        chk("lw_lvalid_pulse", 32'(load_valid), 32'd0);

        run_access(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'd0, 1, 32'h80FF_1122);
        chk("lb_addr", qa, 32'h0000_2000);
        chk("lb_stall", 32'(ns), 32'd2);
        chk("lb_ldata", ld, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'd0, 0, 32'h80FF_1122);
        chk("lbu_ldata", ld, 32'h0000_0080);
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 0, 32'h80FF_1122);
        chk("lh_ldata", ld, 32'hFFFF_80FF);
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 32'h80FF_1122);
        chk("lhu_ldata", ld, 32'h0000_80FF);

        run_access(1'b0, 1'b1, 3'b000, 32'h0000_3002, 32'h0000_00AB, 1, 32'd0);
        chk("sb_wr", 32'(qwr), 32'd1);
        chk("sb_rd", 32'(qrd), 32'd0);
        chk("sb_addr", qa, 32'h0000_3000);
        chk("sb_be", 32'(qbe), 32'h0000_0004);
        chk("sb_wdata", qwd, 32'hABAB_ABAB);
        chk("sb_lvalid", 32'(lv), 32'd0);
        chk("sb_ldata_hold", ld, 32'h0000_80FF);

        run_access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_CDEF, 0, 32'd0);
        chk("sh_be", 32'(qbe), 32'h0000_000C);
        chk("sh_wdata", qwd, 32'hCDEF_CDEF);
        chk("sh_stall", 32'(ns), 32'd1);
        chk("sh_lvalid", 32'(lv), 32'd0);

        // read and write together behave as a store
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_3008, 32'h1122_3344, 0, 32'd0);
        chk("rw_wr", 32'(qwr), 32'd1);
        chk("rw_rd", 32'(qrd), 32'd0);
        chk("rw_be", 32'(qbe), 32'h0000_000F);
        chk("rw_wdata", qwd, 32'h1122_3344);
        chk("rw_lvalid", 32'(lv), 32'd0);

        run_access(1'b0, 1'b1, 3'b011, 32'h0000_300C, 32'h5566_7788, 0, 32'd0);
        chk("sundef_be", 32'(qbe), 32'h0000_000F);
        chk("sundef_wdata", qwd, 32'h5566_7788);
        run_access(1'b1, 1'b0, 3'b110, 32'h0000_4002, 32'd0, 0, 32'hCAFE_F00D);
        chk("lundef_addr", qa, 32'h0000_4000);
        chk("lundef_ldata", ld, 32'hCAFE_F00D);

        // reset while BUSY, then a stray response in IDLE
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_5000;
        @(posedge clk); #1;
        chk("mid_busy_rd", 32'(d_mem_read), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rd", 32'(d_mem_read), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_scnt", stall_cycles, 32'd0);
        rst         = 1'b0;
        mem_read    = 1'b0;
        d_mem_resp  = 1'b1;
        d_mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("stray_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        d_mem_resp = 1'b0;
        chk("stray_lvalid", 32'(load_valid), 32'd0);
        chk("stray_ldata", load_data, 32'd0);
        chk("stray_rd", 32'(d_mem_read), 32'd0);
        chk("stray_wr", 32'(d_mem_write), 32'd0);
        chk("stray_addr", d_mem_address, 32'd0);
        @(posedge clk); #1;
        chk("stray_idle_rd", 32'(d_mem_read), 32'd0);

`ifdef LSU_MISALIGN_CHECK_EN
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_1001;
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        #1;
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_rd", 32'(d_mem_read), 32'd0);
        chk("mis_scnt", stall_cycles, 32'd0);
        @(posedge clk); #1;
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        chk("mis_lvalid", 32'(load_valid), 32'd0);
`else
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'd0, 0, 32'h0000_0055);
        chk("trunc_addr", qa, 32'h0000_1000);
        chk("trunc_ldata", ld, 32'h0000_0055);
        chk("trunc_misalign", 32'(misalign), 32'd0);
`endif

        run_access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 0, 32'h1234_5678);
        chk("post_rst_addr", qa, 32'h0000_6000);
        chk("post_rst_ldata", ld, 32'h1234_5678);
        chk("post_rst_stall", 32'(ns), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage of the RV32I 5-stage pipeline. It sits between the EX/MEM pipeline registers and the D-cache port, and turns the stage's control and data into a word-aligned cache request with byte enables and lane-replicated store data. It stalls the pipeline until the cache responds, then returns load data that is already byte/half selected and sign- or zero-extended to the WB stage.

Parameters:
CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
mem_read  input  1  MEM-stage instruction is a load
mem_write  input  1  MEM-stage instruction is a store
funct3  input  3  load/store width code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010)
addr  input  32  effective address (mem_alu_out)
wdata  input  32  store source (mem_rs2_out)
d_mem_resp  input  1  cache response, one-cycle pulse
d_mem_rdata  input  32  cache read data, valid with d_mem_resp
d_mem_read  output  1  cache read request
d_mem_write  output  1  cache write request
d_mem_address  output  32  {addr[31:2],2'b00}
d_mem_byte_enable  output  4  store byte lanes; 4'b1111 for loads
d_mem_wdata  output  32  lane-replicated store data
stall  output  1  freezes PC and all pipeline registers
load_data  output  32  extended load result for regfilemux lw path
load_valid  output  1  one-cycle pulse, load_data updated
misalign  output  1  misaligned access pulse (optional feature only; otherwise tied 0)
stall_cycles  output  CNT_W  saturating count of cycles with stall high

Behaviour:
- FSM states: IDLE, BUSY. Reset puts the FSM in IDLE and clears every output to 0: d_mem_* signals, load_data, load_valid, misalign, and stall_cycles.
- IDLE with req=(mem_read|mem_write):
  - latch funct3, addr[1:0], the request type, address, byte enable and wdata into request registers;
  - next state is BUSY;
  - stall=1 combinationally in this cycle.
- If mem_read and mem_write are both 1, the access is a store.
- BUSY:
  - d_mem_read or d_mem_write is driven from the request registers, held stable until d_mem_resp;
  - stall = !d_mem_resp;
  - on d_mem_resp: go to IDLE and deassert the request in the next cycle. The pipeline advances in the response cycle.
- Minimum stall is 1 cycle with a 0-wait cache (request in cycle N, BUSY N+1, resp N+1).
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata={4{wdata[7:0]}};
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}};
  - SW: be = 4'b1111.
- Load extraction happens on d_mem_resp, using the latched offset and funct3:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; sign- or zero-extend to 32 bits;
  - load_data is registered and load_valid pulses in the cycle after resp, aligned with WB;
  - load_data holds its value until the next load; stores never pulse load_valid.
- d_mem_resp while in IDLE (stale, e.g. after reset) is ignored.
- Undefined funct3 on an access is treated as a word access.
- stall_cycles increments each cycle stall=1 and saturates at all-ones.
- Reset mid-BUSY: return to IDLE immediately and drop the request. The bench must not assume the cache completes the access.

Optional Feature:
LSU_MISALIGN_CHECK_EN:
- Defined: a misaligned request in IDLE issues no cache access, asserts no stall and no load_valid, and pulses misalign for one cycle. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- Undefined: misalign is tied 0 and misaligned addresses are truncated. SH uses addr[1] only; LW/SW ignore addr[1:0].

Test Plan:
1. LW addr=0x1004, cache resp after 3 cycles with rdata=0xDEADBEEF -> d_mem_address=0x1004, be=1111, stall high 4 cycles, load_valid pulse with load_data=0xDEADBEEF.
2. LB addr=0x2003, rdata=0x80FF1122 -> load_data=0xFFFFFF80; the same access as LBU -> 0x00000080.
3. SB addr=0x3002, wdata=0x000000AB -> d_mem_write=1, be=0100, wdata=0xABABABAB, no load_valid.
4. SH addr=0x3002, wdata=0x1234CDEF, 0-wait cache -> be=1100, wdata=0xCDEFCDEF, stall exactly 1 cycle.
5. rst asserted in BUSY, then a stray d_mem_resp in IDLE -> all outputs 0, FSM stays IDLE, no load_valid.
6. With LSU_MISALIGN_CHECK_EN, LW addr=0x1001 -> misalign pulse, no d_mem_read, stall 0; stall_cycles unchanged.
